seq_gen: RTL
============

# seq_gen

Serial stimulus generator that drives the single-bit `w` input of the sequence-detector state machines (binary and one-hot). It captures a bit pattern and transmits it LSB-first, one bit per clock, with an optional inter-burst gap and repeat count. It also reports busy/done status and its state code, which can be mapped onto board LEDs. It is the transmit end of the `w` stream: the detectors consume exactly what this block emits.

## Interface
Parameters:
- `WIDTH`, 16: pattern register width in bits; must be ≥ 8.
- `REP_W`, 4: width of the repeat-count input.
- `GAP_CYCLES`, 2: idle cycles between repeated bursts; must be ≥ 1.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `Reset` input 1: asynchronous, active-high reset.
- `start` input 1: begin a transmission; sampled in IDLE only.
- `abort` input 1: synchronous cancel of an active transmission.
- `mode` input 1: 0 = pattern mode, 1 = LFSR mode; see Configuration.
- `pattern` input WIDTH: bits to send; bit 0 is sent first.
- `len` input $clog2(WIDTH+1): number of bits per burst.
- `reps` input REP_W: number of extra bursts; total bursts = reps+1.
- `w` output 1: serial bit to the detector, registered.
- `w_valid` output 1: high while `w` carries a pattern bit.
- `busy` output 1: high in SHIFT or GAP.
- `done` output 1: one-cycle pulse when the final burst completes.
- `state` output 3: current state code.

## Operation
- State codes:
  - IDLE = 3'b000
  - SHIFT = 3'b001
  - GAP = 3'b010
  - DONE = 3'b011
  - Codes 100–111 are illegal and recover to IDLE on the next edge.
- **IDLE:**
  - `w` = 0, `w_valid` = 0.
  - On `start` = 1, capture `pattern` into both a shift register and a hold copy, capture `len` (clamped to WIDTH), and capture `reps`.
  - If the clamped `len` = 0, go to DONE; otherwise go to SHIFT.
- **SHIFT:**
  - `w` = shift register bit 0 and `w_valid` = 1.
  - Each cycle: shift right by one (zero fill) and increment the bit counter.
  - After the `len`-th bit: if the repeats remaining > 0, go to GAP; otherwise go to DONE.
- **GAP:**
  - `w` = 0, `w_valid` = 0 for exactly GAP_CYCLES cycles.
  - On the final gap cycle: reload the shift register from the hold copy, clear the bit counter, decrement the repeats remaining, and go to SHIFT.
- **DONE:** `done` = 1 and `w` = 0 for one cycle, then IDLE.
- **`abort`:**
  - In SHIFT or GAP, `abort` forces IDLE on the next edge.
  - No `done` pulse; `w` and `w_valid` are 0 from that edge on.
  - `abort` has priority over every other transition.
- **Ignored inputs:**
  - `start` is ignored outside IDLE.
  - When `start` and `abort` are both high in IDLE, `start` wins.
- Changes to `pattern`, `len` and `reps` after capture have no effect until the next start.

## Timing
- **Reset:** while `Reset` is high, all outputs are 0, `state` = IDLE, and all internal registers are cleared, effective immediately and independent of `clk`. Reset mid-burst truncates the stream with no `done` pulse.
- **Start latency:** with `start` sampled at edge E0, the first bit appears on `w` after E0 and stays valid until E1.
- **Burst:** bit k is valid between edges Ek and Ek+1.
  - A burst of `len` bits occupies `len` cycles back-to-back, with no bubbles.
  - Between repeated bursts there are exactly GAP_CYCLES cycles with `w_valid` = 0.
- **Completion:**
  - `done` is high in the cycle after the last bit; `busy` is low in that same cycle.
  - IDLE follows one cycle later, so the earliest accepted restart is 2 cycles after the last bit.
- **Total duration:** start to `done` = (reps+1)·len + reps·GAP_CYCLES cycles, then 1 cycle of DONE.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- **`SEQGEN_LFSR_EN` defined:** LFSR mode is compiled in.
  - `start` with `mode` = 1 seeds an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) from `pattern[7:0]`; a zero seed is replaced by 8'h01.
  - `w` = LFSR bit 0, and the LFSR advances once per SHIFT cycle.
  - `len`, `reps` and the gap apply unchanged; repeated bursts reseed from the captured seed.
- **`SEQGEN_LFSR_EN` undefined:** the LFSR logic is absent and `mode` is ignored (always pattern mode); the port list is unchanged.

## Test plan
- **Reset:** assert `Reset` mid-SHIFT with no clock edge → `w`, `w_valid`, `busy` and `done` go to 0 and `state` = 000 immediately; no `done` afterwards.
- **Single burst:** `pattern` = 16'h000D, `len` = 4, `reps` = 0, start at E0 → `w` = 1,0,1,1 in cycles 1–4 with `w_valid` = 1; `done` = 1 in cycle 5; `state` = 000 in cycle 6.
- **Repeats:** `pattern` = 16'h0005, `len` = 3, `reps` = 2, GAP_CYCLES = 2 → `w` = 101,00,101,00,101 over 13 cycles; `w_valid` is low only in the gap cycles; `done` in cycle 14.
- **Edge cases:**
  - `len` = 0 → DONE immediately and `w_valid` never rises.
  - `len` = 20 with WIDTH = 16 → exactly 16 bits are sent.
  - `start` pulsed during SHIFT → ignored.
- **Abort:** abort in the third bit of a 6-bit burst → IDLE on the next edge, no `done`; a new start 1 cycle later transmits correctly.
- **LFSR (`SEQGEN_LFSR_EN`):** `mode` = 1, seed 8'h00, `len` = 8 → `w` sequence matches the reference LFSR seeded with 8'h01. Without the macro, `mode` = 1 yields the raw `pattern` bits.

Source files
------------

// File: rtl/seq_gen.sv
// Serial pattern / LFSR stimulus generator for the sequence detectors' w input.
// Optional LFSR mode is compiled in with `define SEQGEN_LFSR_EN.
module seq_gen #(
   parameter int WIDTH      = 16,
   parameter int REP_W      = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic                         clk,
   input  logic                         Reset,
   input  logic                         start,
   input  logic                         abort,
   input  logic                         mode,
   input  logic [WIDTH-1:0]             pattern,
   input  logic [$clog2(WIDTH+1)-1:0]   len,
   input  logic [REP_W-1:0]             reps,
   output logic                         w,
   output logic                         w_valid,
   output logic                         busy,
   output logic                         done,
   output logic [2:0]                   state
);

   localparam int LW = $clog2(WIDTH+1);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [2:0] IDLE  = 3'b000;
   localparam logic [2:0] SHIFT = 3'b001;
   localparam logic [2:0] GAP   = 3'b010;
   localparam logic [2:0] DONE  = 3'b011;

   logic [2:0]       state_q;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] hold;
   logic [LW-1:0]    len_q;
   logic [LW-1:0]    len_clamp;
   logic [LW-1:0]    bit_cnt;
   logic [REP_W-1:0] reps_left;
   logic [GW-1:0]    gap_cnt;
   logic             first_bit;
   logic             shift_bit;
   logic             reload_bit;

`ifdef SEQGEN_LFSR_EN
   logic       mode_q;
   logic [7:0] lfsr;
   logic [7:0] lfsr_nx;
   logic [7:0] seed;
   logic [7:0] seed_q;

   // x^8+x^6+x^5+x^4+1, right-shifting Fibonacci form; bit 0 is the output tap
   always_comb begin
      seed       = (pattern[7:0] == 8'h00) ? 8'h01 : pattern[7:0];
      lfsr_nx    = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[4], lfsr[7:1]};
      first_bit  = mode   ? seed[0]    : pattern[0];
      shift_bit  = mode_q ? lfsr_nx[0] : sreg[0];
      reload_bit = mode_q ? seed_q[0]  : hold[0];
   end
`else
   logic unused_mode;
   assign unused_mode = mode;

   always_comb begin
      first_bit  = pattern[0];
      shift_bit  = sreg[0];
      reload_bit = hold[0];
   end
`endif

   always_comb begin
      len_clamp = (len > LW'(WIDTH)) ? LW'(WIDTH) : len;
   end

   assign state = state_q;

   // sreg holds the bits still to send, so its bit 0 is the next w value
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= IDLE;
         sreg      <= '0;
         hold      <= '0;
         len_q     <= '0;
         bit_cnt   <= '0;
         reps_left <= '0;
         gap_cnt   <= '0;
         w         <= 1'b0;
         w_valid   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef SEQGEN_LFSR_EN
         mode_q    <= 1'b0;
         lfsr      <= '0;
         seed_q    <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               w       <= 1'b0;
               w_valid <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
               if (start) begin
                  sreg      <= {1'b0, pattern[WIDTH-1:1]};
                  hold      <= pattern;
                  len_q     <= len_clamp;
                  reps_left <= reps;
                  bit_cnt   <= LW'(1);
                  gap_cnt   <= '0;
`ifdef SEQGEN_LFSR_EN
                  mode_q    <= mode;
                  seed_q    <= seed;
                  lfsr      <= seed;
`endif
                  if (len_clamp == '0) begin
                     state_q <= DONE;
                     done    <= 1'b1;
                  end else begin
                     state_q <= SHIFT;
                     w       <= first_bit;
                     w_valid <= 1'b1;
                     busy    <= 1'b1;
                  end
               end
            end

            SHIFT: begin
               if (abort) begin
                  state_q <= IDLE;
                  w       <= 1'b0;
                  w_valid <= 1'b0;
                  busy    <= 1'b0;
               end else if (bit_cnt == len_q) begin
                  w       <= 1'b0;
                  w_valid <= 1'b0;
                  if (reps_left != '0) begin
                     state_q <= GAP;
                     gap_cnt <= '0;
                  end else begin
                     state_q <= DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end
               end else begin
                  sreg    <= {1'b0, sreg[WIDTH-1:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  w       <= shift_bit;
`ifdef SEQGEN_LFSR_EN
                  lfsr    <= lfsr_nx;
`endif
               end
            end

            GAP: begin
               if (abort) begin
                  state_q <= IDLE;
                  w       <= 1'b0;
                  w_valid <= 1'b0;
                  busy    <= 1'b0;
               end else if (gap_cnt == GW'(GAP_CYCLES-1)) begin
                  state_q   <= SHIFT;
                  sreg      <= {1'b0, hold[WIDTH-1:1]};
                  bit_cnt   <= LW'(1);
                  reps_left <= reps_left - 1'b1;
                  w         <= reload_bit;
                  w_valid   <= 1'b1;
`ifdef SEQGEN_LFSR_EN
                  lfsr      <= seed_q;
`endif
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end

            DONE: begin
               state_q <= IDLE;
               done    <= 1'b0;
               w       <= 1'b0;
               w_valid <= 1'b0;
               busy    <= 1'b0;
            end

            default: begin
               state_q <= IDLE;
               w       <= 1'b0;
               w_valid <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule
